// File: rtl/banked_regfile.sv
// Banked register file: shared low registers, per-bank copies from BANK_LO up,
// and an exception entry/return stack that tracks which bank is live.
`timescale 1ns/1ps

module banked_regfile #(
  parameter int DW      = 32,
  parameter int NBANK   = 4,
  parameter int BANK_LO = 13,
  parameter int NEST    = 2,
  parameter int NRD     = 4,
  localparam int BW     = ($clog2(NBANK) > 1) ? $clog2(NBANK) : 1,
  localparam int SW     = $clog2(NEST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [4*NRD-1:0]  i_rd_code,
  output logic [DW*NRD-1:0] o_rd_data,
  input  logic [DW-1:0]     i_pc_next,
  input  logic              i_wr_en_ex,
  input  logic [3:0]        i_wr_code_ex,
  input  logic [DW-1:0]     i_wr_data_ex,
  input  logic              i_wr_en_wb,
  input  logic [3:0]        i_wr_code_wb,
  input  logic [DW-1:0]     i_wr_data_wb,
  output logic              o_pc_en,
  output logic [DW-1:0]     o_pc_data,
  input  logic              i_exc_req,
  input  logic [BW-1:0]     i_exc_bank,
  input  logic [DW-1:0]     i_exc_lr,
  output logic              o_exc_ack,
  input  logic              i_ret_req,
  output logic              o_ret_ack,
  output logic [BW-1:0]     o_bank,
  output logic [SW-1:0]     o_depth,
  output logic              o_nest_err
);

  localparam logic [SW-1:0] NEST_V    = SW'(NEST);
  localparam logic [BW:0]   NBANK_V   = (BW + 1)'(NBANK);
  localparam logic [3:0]    BANK_LO_V = 4'(BANK_LO);
  // R14 is only banked (and thus only an LR target) when BANK_LO leaves it above the split.
  localparam bit            LR_EN     = (BANK_LO <= 14);

  typedef logic [DW-1:0] word_t;

  word_t         shared_q [15];
  word_t         banked_q [NBANK][15];
  logic [BW-1:0] stack_q  [NEST];
  logic [BW-1:0] bank_q;
  logic [SW-1:0] depth_q;
  logic          exc_ack_q;
  logic          ret_ack_q;
  logic          nest_err_q;

  // ---------------------------------------------------------------------------
  // Entry / return arbitration
  // ---------------------------------------------------------------------------
  logic          exc_legal;
  logic          exc_accept;
  logic          exc_reject;
  logic          ret_accept;
  logic          ret_reject;
  logic [BW-1:0] pop_bank;

  assign exc_legal  = (depth_q < NEST_V) && (i_exc_bank != '0) &&
                      ({1'b0, i_exc_bank} < NBANK_V);
  assign exc_accept = en && i_exc_req && exc_legal;
  assign exc_reject = en && i_exc_req && !exc_legal;
  // Entry has priority: a simultaneous return is simply not looked at.
  assign ret_accept = en && !i_exc_req && i_ret_req && (depth_q != '0);
  assign ret_reject = en && !i_exc_req && i_ret_req && (depth_q == '0);

  always_comb begin
    pop_bank = '0;
    for (int k = 0; k < NEST; k++) begin
      if (depth_q == SW'(k + 1)) pop_bank = stack_q[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic [14:0] hit_ex;
  logic [14:0] hit_wb;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit_ex = '0;
    hit_wb = '0;
    for (int i = 0; i < 15; i++) begin
      hit_ex[i] = i_wr_en_ex && (i_wr_code_ex == 4'(i));
      hit_wb[i] = i_wr_en_wb && (i_wr_code_wb == 4'(i));
    end
    // The entry LR load owns R14 this cycle; pipeline writes to it are dropped.
    if (LR_EN && exc_accept) begin
      hit_ex[14] = 1'b0;
      hit_wb[14] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  // NOTE: the arrays are cleared on reset because software relies on reading
  // zeros from untouched registers; this costs a reset on every flop.
  // NOTE: state is updated with non-blocking assignments only, so the order of
  // statements below expresses priority (later wins) without evaluation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        shared_q[i] <= '0;
      end
      for (int b = 0; b < NBANK; b++) begin
        for (int i = 0; i < 15; i++) begin
          banked_q[b][i] <= '0;
        end
      end
    end else if (en) begin
      for (int i = 0; i < 15; i++) begin
        if (i < BANK_LO) begin
          if (hit_ex[i])      shared_q[i] <= i_wr_data_ex;
          else if (hit_wb[i]) shared_q[i] <= i_wr_data_wb;
        end else begin
          if (hit_ex[i])      banked_q[bank_q][i] <= i_wr_data_ex;
          else if (hit_wb[i]) banked_q[bank_q][i] <= i_wr_data_wb;
        end
      end
      if (LR_EN && exc_accept) banked_q[i_exc_bank][14] <= i_exc_lr;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank / return stack / handshake flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NEST; k++) begin
        stack_q[k] <= '0;
      end
      bank_q     <= '0;
      depth_q    <= '0;
      exc_ack_q  <= 1'b0;
      ret_ack_q  <= 1'b0;
      nest_err_q <= 1'b0;
    end else begin
      if (exc_accept) begin
        for (int k = 0; k < NEST; k++) begin
          if (depth_q == SW'(k)) stack_q[k] <= bank_q;
        end
        bank_q  <= i_exc_bank;
        depth_q <= depth_q + 1'b1;
      end else if (ret_accept) begin
        bank_q  <= pop_bank;
        depth_q <= depth_q - 1'b1;
      end
      exc_ack_q  <= exc_accept;
      ret_ack_q  <= ret_accept;
      nest_err_q <= exc_reject | ret_reject;
    end
  end

  // Pulses are masked while stalled so a stall never shows a stale acknowledge.
  assign o_exc_ack  = exc_ack_q & en;
  assign o_ret_ack  = ret_ack_q & en;
  assign o_nest_err = nest_err_q & en;
  assign o_bank     = bank_q;
  assign o_depth    = depth_q;

  // ---------------------------------------------------------------------------
  // PC redirect and read ports
  // ---------------------------------------------------------------------------
  logic pc_ex;
  logic pc_wb;

  assign pc_ex     = i_wr_en_ex && (i_wr_code_ex == 4'hF);
  assign pc_wb     = i_wr_en_wb && (i_wr_code_wb == 4'hF);
  assign o_pc_en   = pc_ex | pc_wb;
  assign o_pc_data = pc_wb ? i_wr_data_wb : i_wr_data_ex;

  always_comb begin
    logic [3:0] code;
    code      = '0;
    o_rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      code = i_rd_code[4*p +: 4];
      if (code == 4'hF)           o_rd_data[DW*p +: DW] = i_pc_next;
      else if (code < BANK_LO_V)  o_rd_data[DW*p +: DW] = shared_q[code];
      else                        o_rd_data[DW*p +: DW] = banked_q[bank_q][code];
    end
  end

endmodule

// File: doc/banked_regfile.md
BANKED_REGFILE -- requirements
Module: banked_regfile

Interface
REQ-001 Parameter DW, default 32, register data width.
REQ-002 Parameter NBANK, default 4, number of register banks (bank 0 = user), NBANK >= 2.
REQ-003 Parameter BANK_LO, default 13, lowest banked register index (0..14); registers below it are shared across all banks.
REQ-004 Parameter NEST, default 2, exception return-stack depth, NEST >= 1.
REQ-005 Parameter NRD, default 4, number of read ports; BW = max(1, clog2(NBANK)), SW = clog2(NEST+1).
REQ-006 clk  input  1  clock.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  global update enable; 0 = full stall.
REQ-009 i_rd_code  input  4*NRD  packed read register indices.
REQ-010 o_rd_data  output  DW*NRD  packed read data.
REQ-011 i_pc_next  input  DW  value returned for index 15.
REQ-012 i_wr_en_ex / i_wr_code_ex / i_wr_data_ex  input  1/4/DW  EX write port.
REQ-013 i_wr_en_wb / i_wr_code_wb / i_wr_data_wb  input  1/4/DW  WB write port.
REQ-014 o_pc_en / o_pc_data  output  1/DW  PC write redirect.
REQ-015 i_exc_req / i_exc_bank / i_exc_lr  input  1/BW/DW  exception entry request, target bank, return address.
REQ-016 o_exc_ack  output  1  one-cycle entry acceptance.
REQ-017 i_ret_req  input  1  exception return request.
REQ-018 o_ret_ack  output  1  one-cycle return acceptance.
REQ-019 o_bank  output  BW  current bank; o_depth  output  SW  return-stack occupancy; o_nest_err  output  1  one-cycle error pulse.

Function
REQ-020 Read ports combinational: index 15 -> i_pc_next; index < BANK_LO -> shared register; otherwise banked register of o_bank.
REQ-021 Reads return pre-write (registered) contents; no write-through bypass.
REQ-022 On rising clk with en=1, writes to index 0..14 update the copy selected by the current o_bank (shared or banked).
REQ-023 EX and WB writing the same index in one cycle: EX data stored, WB dropped.
REQ-024 o_pc_en = (EX or WB write enabled with code 15); o_pc_data = WB data if WB targets 15, else EX data; combinational, independent of en; index 15 never stored.
REQ-025 Entry accepted when en=1, i_exc_req=1, o_depth < NEST, i_exc_bank != 0 and < NBANK: next cycle o_bank = i_exc_bank, old o_bank pushed, o_depth+1, target bank R14 = i_exc_lr, o_exc_ack=1 for that one cycle.
REQ-026 Entry LR load wins over any same-cycle EX/WB write to R14; other same-cycle writes go to the pre-entry bank.
REQ-027 Entry with o_depth = NEST, or bank 0 / bank >= NBANK: no state change, no ack, o_nest_err pulses 1 cycle (once per cycle while request held).
REQ-028 Return accepted when en=1, i_ret_req=1, o_depth > 0: o_bank = popped value, o_depth-1, o_ret_ack 1 cycle; same-cycle writes go to the pre-return bank.
REQ-029 Return with o_depth = 0: no state change, no ack, o_nest_err pulses.
REQ-030 i_exc_req and i_ret_req together: entry evaluated, return ignored that cycle.
REQ-031 en=0: no register, bank, stack or ack updates; o_exc_ack/o_ret_ack/o_nest_err = 0; o_pc_en still combinational.
REQ-032 If BANK_LO = 15, no banked registers; entry still switches bank/stack, LR load suppressed.

Reset
REQ-033 rst_n low asynchronously clears all shared and banked registers, return stack, o_bank=0, o_depth=0, o_exc_ack=0, o_ret_ack=0, o_nest_err=0.
REQ-034 Reset mid-operation discards any pending request; first post-reset cycle treats inputs as fresh.

Verification (DW=32, NBANK=4, BANK_LO=13, NEST=2, NRD=4)
REQ-035 Write R3=0x11 in bank 0, enter bank 2, read R3 -> 0x11; write R13=0xAA, return, read R13 -> 0 (bank 0 copy).
REQ-036 EX writes R5=0x1, WB writes R5=0x2 same cycle -> R5=0x1; EX R15=0x100 with WB R15=0x200 -> o_pc_en=1, o_pc_data=0x200.
REQ-037 Enter bank 1 (lr 0x40), enter bank 3 (lr 0x80), third entry -> o_nest_err=1, o_depth=2, o_bank=3; R14 in bank 3 = 0x80.
REQ-038 Entry to bank 1 with same-cycle EX write R14=0x55 -> bank 1 R14=i_exc_lr, bank 0 R14 unchanged.
REQ-039 Return at o_depth=0 -> o_nest_err=1, o_ret_ack=0; en=0 with i_exc_req=1 -> no ack, o_bank unchanged.
REQ-040 Assert rst_n=0 at depth 2 -> o_bank=0, o_depth=0, all reads 0 except index 15.
